// File: rtl/modular_addsub_ctrl_if.sv
// Request and adder-side bus of the 384-bit modular add/sub controller.
// slave: the controller itself; master: scheduler plus adder instance.
interface modular_addsub_ctrl_if;
  logic         start;
  logic         subtract;
  logic [383:0] in_a;
  logic [383:0] in_b;
  logic [383:0] modulus;
  logic [383:0] result;
  logic         done;
  logic         busy;
  logic         add_start;
  logic [383:0] add_a;
  logic [383:0] add_b;
  logic         add_cin;
  logic [384:0] add_c;
  logic         add_done;

  modport slave (
    input  start, subtract, in_a, in_b, modulus,
    input  add_c, add_done,
    output result, done, busy,
    output add_start, add_a, add_b, add_cin
  );

  modport master (
    output start, subtract, in_a, in_b, modulus,
    output add_c, add_done,
    input  result, done, busy,
    input  add_start, add_a, add_b, add_cin
  );
endinterface

// File: rtl/modular_addsub_ctrl.sv
// (A +/- B) mod M over two passes of an external registered 384-bit adder.
// MODADD_CONST_TIME_EN: always run both passes (data-independent latency).
module modular_addsub_ctrl (
  input logic                  clk,
  input logic                  resetn,
  modular_addsub_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADD1,
    WAIT1,
    ADD2,
    WAIT2,
    FIN
  } state_t;

  state_t       state;
  state_t       state_n;

  logic         sub_q;
  logic [383:0] m_q;
  logic [384:0] s_q;
  logic [383:0] result_q;
  logic [383:0] add_a_q;
  logic [383:0] add_b_q;
  logic         add_cin_q;

  logic         skip;
  logic [383:0] fin_res;

  // A subtract without borrow is already reduced after pass 1
`ifdef MODADD_CONST_TIME_EN
  assign skip = 1'b0;
`else
  assign skip = sub_q & bus.add_c[384];
`endif

  // Pick the reduced value once pass 2 (D on add_c) completes
  always_comb begin
    fin_res = bus.add_c[383:0];
    if (sub_q) begin
      if (s_q[384])
        fin_res = s_q[383:0];
    end else begin
      if (!(s_q[384] | bus.add_c[384]))
        fin_res = s_q[383:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state sequencing of the two adder passes
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (bus.start) state_n = ADD1;
      ADD1:  state_n = WAIT1;
      WAIT1: begin
        if (bus.add_done)
          state_n = skip ? FIN : ADD2;
      end
      ADD2:  state_n = WAIT2;
      WAIT2: if (bus.add_done) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latching, pass-2 muxing and result capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sub_q     <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
      result_q  <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sub_q     <= bus.subtract;
            m_q       <= bus.modulus;
            add_a_q   <= bus.in_a;
            add_b_q   <= bus.subtract ? ~bus.in_b
                                      : bus.in_b;
            add_cin_q <= bus.subtract;
          end
        end
        WAIT1: begin
          if (bus.add_done) begin
            s_q       <= bus.add_c;
            add_a_q   <= bus.add_c[383:0];
            add_b_q   <= sub_q ? m_q : ~m_q;
            add_cin_q <= ~sub_q;
            if (skip)
              result_q <= bus.add_c[383:0];
          end
        end
        WAIT2: begin
          if (bus.add_done)
            result_q <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.add_start = (state == ADD1) |
                         (state == ADD2);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.result    = result_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;

endmodule

// File: tb/tb_modular_addsub_ctrl.sv
// Bench for modular_addsub_ctrl: vector table, corner sequences,
// random operations against a plain-arithmetic modular model.
module tb_modular_addsub_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  modular_addsub_ctrl_if bus();

  modular_addsub_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [383:0] act,
                     input logic [383:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // adder stub with configurable latency
  int           stub_lat = 1;
  int           stub_cnt = 0;
  logic [384:0] stub_c = '0;
  logic         stub_done = 1'b0;
  logic         inj_done = 1'b0;
  logic [383:0] la = '0;
  logic [383:0] lb = '0;
  logic         lc = 1'b0;

  assign bus.add_c    = stub_c;
  assign bus.add_done = stub_done | inj_done;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (stub_cnt > 0) begin
      if (bus.busy)
        chk({bus.add_a, bus.add_b, bus.add_cin} === {la, lb, lc},
            "operand hold", bus.add_a, la);
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
    if (bus.add_start) begin
      la     <= bus.add_a;
      lb     <= bus.add_b;
      lc     <= bus.add_cin;
      stub_c <= {1'b0, bus.add_a} + {1'b0, bus.add_b}
                + 385'(bus.add_cin);
      if (stub_lat <= 1) stub_done <= 1'b1;
      else stub_cnt <= stub_lat - 1;
    end
  end

  // reference model
  function automatic logic [383:0] ref_res(
      input logic [383:0] a, input logic [383:0] b,
      input logic [383:0] m, input logic sub);
    logic [385:0] t;
    if (sub) begin
      if (a >= b) t = {2'b0, a} - {2'b0, b};
      else t = {2'b0, a} + {2'b0, m} - {2'b0, b};
    end else begin
      t = {2'b0, a} + {2'b0, b};
      if (t >= {2'b0, m}) t = t - {2'b0, m};
    end
    return t[383:0];
  endfunction

  function automatic int ref_lat(input logic [383:0] a,
                                 input logic [383:0] b,
                                 input logic sub);
    int passes;
    passes = 2;
`ifndef MODADD_CONST_TIME_EN
    if (sub && a >= b) passes = 1;
`endif
    return passes * (stub_lat + 1) + 1;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic poke_start();
    bus.start    = 1'b1;
    bus.subtract = 1'($urandom_range(0, 1));
    bus.in_a     = rand384();
    bus.in_b     = rand384();
    bus.modulus  = rand384();
  endtask

  // poke: 0 none, -1 start during done cycle, >0 start at that cycle
  task automatic run_op(input logic [383:0] a, input logic [383:0] b,
                        input logic [383:0] m, input logic sub,
                        input int poke, input logic [383:0] exp,
                        input string nm);
    int want;
    int cyc;
    bit got;
    bit busy_ok;
    want = ref_lat(a, b, sub);
    bus.start    = 1'b1;
    bus.subtract = sub;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.modulus  = m;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    got = 0;
    busy_ok = 1;
    while (!got && cyc <= 60) begin
      if (poke > 0 && cyc == poke) poke_start();
      else bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.done === 1'b1) got = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk(got, {nm, " done seen"}, 384'(got), 384'(1));
    chk(cyc == want, {nm, " latency"}, 384'(cyc), 384'(want));
    chk(bus.result === exp, {nm, " result"}, bus.result, exp);
    chk(busy_ok, {nm, " busy"}, 384'(busy_ok), 384'(1));
    if (poke < 0) poke_start();
    @(negedge clk);
    bus.start = 1'b0;
    chk(bus.done === 1'b0 && bus.busy === 1'b0,
        {nm, " idle after done"},
        384'({bus.done, bus.busy}), 384'(0));
  endtask

  typedef struct {
    logic [383:0] a;
    logic [383:0] b;
    logic [383:0] m;
    logic         sub;
    int           lat;
    int           poke;
    logic [383:0] exp;
    string        nm;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [383:0] a, input logic [383:0] b,
                         input logic [383:0] m, input logic sub,
                         input int lat, input int poke,
                         input logic [383:0] exp, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.m = m; v.sub = sub;
    v.lat = lat; v.poke = poke; v.exp = exp; v.nm = nm;
    vt.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] ones;
    logic [383:0] a;
    logic [383:0] b;
    logic [383:0] m;
    logic         sub;
    ones = '1;
    bus.start    = 1'b0;
    bus.subtract = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.modulus  = '0;

    add_vec(50, 60, 97, 0, 1, 0, 13, "add no wrap");
    add_vec(ones - 1, ones - 1, ones, 0, 1, 0, ones - 2, "add carry");
    add_vec(10, 20, 97, 1, 1, 0, 87, "sub borrow");
    add_vec(20, 10, 97, 1, 1, 0, 10, "sub no borrow");
    add_vec(50, 60, 97, 0, 1, 2, 13, "start at k+2");
    add_vec(96, 96, 97, 0, 1, -1, 95, "start in FIN");
    add_vec(0, 96, 97, 1, 1, 0, 1, "b2b sub");
    add_vec(0, 0, 1, 1, 1, 0, 0, "m=1 sub");
    add_vec(50, 60, 97, 0, 3, 0, 13, "slow add");
    add_vec(20, 10, 97, 1, 3, 0, 10, "slow sub");
    add_vec(10, 20, 97, 1, 3, 0, 87, "slow sub borrow");

    repeat (3) @(negedge clk);
    chk({bus.result, bus.done, bus.busy, bus.add_start,
         bus.add_a, bus.add_b, bus.add_cin} === '0,
        "reset state", bus.result, '0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      stub_lat = vt[i].lat;
      chk(ref_res(vt[i].a, vt[i].b, vt[i].m, vt[i].sub) === vt[i].exp,
          {vt[i].nm, " model"},
          ref_res(vt[i].a, vt[i].b, vt[i].m, vt[i].sub), vt[i].exp);
      run_op(vt[i].a, vt[i].b, vt[i].m, vt[i].sub,
             vt[i].poke, vt[i].exp, vt[i].nm);
    end

    // reset in WAIT2, then a stale add_done
    stub_lat = 1;
    bus.start    = 1'b1;
    bus.subtract = 1'b0;
    bus.in_a     = 50;
    bus.in_b     = 60;
    bus.modulus  = 97;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.busy === 1'b1, "busy before reset",
        384'(bus.busy), 384'(1));
    resetn = 1'b0;
    #1;
    chk({bus.result, bus.done, bus.busy, bus.add_start,
         bus.add_a, bus.add_b, bus.add_cin} === '0,
        "mid-op reset", bus.result, '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    chk(bus.busy === 1'b0 && bus.done === 1'b0 &&
        bus.add_start === 1'b0,
        "stale add_done", 384'({bus.busy, bus.done}), '0);
    @(negedge clk);
    chk(bus.busy === 1'b0 && bus.done === 1'b0 &&
        bus.result === '0,
        "idle after stale", bus.result, '0);
    run_op(20, 90, 97, 0, 0, 13, "after reset");

    // random operations
    for (int i = 0; i < 40; i++) begin
      stub_lat = $urandom_range(1, 3);
      m = rand384();
      if ($urandom_range(0, 1) == 1)
        m = m >> $urandom_range(300, 380);
      if (m == '0) m = 1;
      a = rand384() % m;
      b = rand384() % m;
      if ($urandom_range(0, 4) == 0) b = a;
      sub = 1'($urandom_range(0, 1));
      run_op(a, b, m, sub, 0, ref_res(a, b, m, sub), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
